// File: rtl/rom_dl_writer.sv
// Queues ioctl download bytes in a 4-deep FIFO and replays them as toggle-handshake SDRAM writes.
// Push->req latency 1 clk, one write in flight; a push into a full FIFO is dropped and flags overflow.

module rom_dl_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         res_n_i,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign pop_ok   = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign push_ok  = push & (~full | pop_ok);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module rom_dl_writer #(
  parameter logic [24:0] SP_BASE  = 25'h12000,
  parameter logic [15:0] RST_HOLD = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        ioctl_downl,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        soft_rst,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port1_we,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        port2_we,
  output logic        dl_busy,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);
  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t      state;
  logic        p2_issued;
  logic        wr_q;
  logic        downl_q;
  logic [15:0] cnt;

  logic        push;
  logic        pop;
  logic        drop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [32:0] head;
  logic [24:0] head_addr;
  logic [7:0]  head_data;
  logic        is_sprite;
  logic [23:0] sp;
  logic        ack_done;
  logic        busy_cond;

  assign push      = ioctl_downl & ioctl_wr & ~wr_q;
  assign pop       = (state == IDLE) & ~fifo_empty;
  assign drop      = push & fifo_full & ~pop;
  assign head_addr = head[32:8];
  assign head_data = head[7:0];
  assign is_sprite = (head_addr >= SP_BASE);
  // only bits 23:0 of the sprite offset feed the port, so the borrow into bit 24 is irrelevant
  assign sp        = head_addr[23:0] - SP_BASE[23:0];
  assign ack_done  = (port1_ack == port1_req) & (~p2_issued | (port2_ack == port2_req));
  assign busy_cond = ioctl_downl | ~fifo_empty | (state == WAIT_ACK);

  assign port1_we = dl_busy;
  assign port2_we = dl_busy;

  rom_dl_fifo #(.W(33), .DEPTH(4)) u_fifo (
    .clk_i    (clk_i),
    .res_n_i  (res_n_i),
    .push     (push),
    .push_dat ({ioctl_addr, ioctl_dout}),
    .pop      (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state     <= IDLE;
      p2_issued <= 1'b0;
      port1_req <= 1'b0;
      port1_a   <= '0;
      port1_ds  <= '0;
      port1_d   <= '0;
      port2_req <= 1'b0;
      port2_a   <= '0;
      port2_ds  <= '0;
      port2_d   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            port1_a   <= head_addr[23:1];
            port1_ds  <= {head_addr[0], ~head_addr[0]};
            port1_d   <= {head_data, head_data};
            port1_req <= ~port1_req;
            p2_issued <= is_sprite;
            if (is_sprite) begin
              port2_a   <= {sp[23:16], sp[13:0], sp[15]};
              port2_ds  <= {sp[14], ~sp[14]};
              port2_d   <= {head_data, head_data};
              port2_req <= ~port2_req;
            end
            state <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      wr_q       <= 1'b0;
      downl_q    <= 1'b0;
      overflow   <= 1'b0;
      dl_busy    <= 1'b0;
      rom_loaded <= 1'b0;
      cnt        <= RST_HOLD;
      core_reset <= 1'b1;
    end else begin
      wr_q    <= ioctl_wr;
      downl_q <= ioctl_downl;
      dl_busy <= busy_cond;
      if (drop)                            overflow <= 1'b1;
      else if (ioctl_downl && !downl_q)    overflow <= 1'b0;
      if (dl_busy && !busy_cond)           rom_loaded <= 1'b1;
      if (soft_rst || !rom_loaded)         cnt <= RST_HOLD;
      else if (cnt != 16'd0)               cnt <= cnt - 16'd1;
      // cnt==1 gives the second, delayed one-cycle reset pulse after release
      core_reset <= soft_rst | ~rom_loaded | dl_busy | (cnt == 16'd1);
    end
  end
endmodule
